ssb_demod_scheduler: RTL and testbench

- Time-shares one SSB sideband combiner ((I ± Q) >>> 1) among NUM_CH receiver channels.
- Each channel presents phase-shifted I/Q sample pairs on a valid/ready handshake; a round-robin arbiter accepts one pair per clock.
- Holds a per-channel USB/LSB mode register; on a mode change, mutes the first MUTE_LEN outputs of that channel to suppress clicks.
- Sits between the per-channel Hilbert/phase-shift stages and the audio filter/decimator.

---
 rtl/ssb_demod_pkg.sv | 20 ++
 rtl/ssb_demod_scheduler_rr_arbiter.sv | 37 +++
 rtl/ssb_demod_scheduler.sv | 138 +++++++++++++
 tb/tb_ssb_demod_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssb_demod_pkg.sv
// Shared types and constants for the SSB demodulator scheduler.
// Latency: n/a (declarations only). Backpressure: n/a.
// The stage-1 record is sized by DEF_DW and a 4-bit channel field (up to 16 channels).
package ssb_demod_pkg;

    localparam logic MODE_USB = 1'b1;
    localparam logic MODE_LSB = 1'b0;

    localparam int DEF_DW   = 12;
    localparam int CH_MAXW  = 4;

    typedef struct packed {
        logic signed [DEF_DW-1:0] i;
        logic signed [DEF_DW-1:0] q;
        logic [CH_MAXW-1:0]       ch;
        logic                     usb;
        logic                     mute;
    } s1_rec_t;

endpackage

// File: rtl/ssb_demod_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping to 0.
// Latency: combinational. Backpressure: none, grant only reflects req.
// Callers advance ptr past the granted index to get fairness.
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CHW    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CHW-1:0]    ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CHW-1:0]    grant_idx,
    output logic              any
);

    logic [CHW:0] cand;

    // Walk offsets from the far end down so the smallest offset is the last writer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            cand = {1'b0, ptr} + (CHW+1)'(off);
            if (cand >= (CHW+1)'(NUM_CH)) begin
                cand = cand - (CHW+1)'(NUM_CH);
            end
            if (req[cand[CHW-1:0]]) begin
                grant                 = '0;
                grant[cand[CHW-1:0]]  = 1'b1;
                grant_idx             = cand[CHW-1:0];
                any                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssb_demod_scheduler.sv
// Time-shares one (I +/- Q) >>> 1 sideband combiner across NUM_CH channels, with click-mute on mode change.
// Latency: accepted pair appears on out_valid two clocks later; one pair accepted per clock.
// Backpressure: none downstream; req_ready is one-hot on the round-robin winner whenever any channel is valid.
module ssb_demod_scheduler
    import ssb_demod_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int DW       = DEF_DW,
    parameter  int MUTE_LEN = 4,
    localparam int CHW      = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    req_valid,
    output logic [NUM_CH-1:0]    req_ready,
    input  logic [NUM_CH*DW-1:0] req_i,
    input  logic [NUM_CH*DW-1:0] req_q,
    input  logic                 cfg_we,
    input  logic [CHW-1:0]       cfg_ch,
    input  logic                 cfg_usb,
    output logic                 out_valid,
    output logic [CHW-1:0]       out_ch,
    output logic [DW-1:0]        out_data,
    output logic [NUM_CH-1:0]    mode_q
);

    logic [NUM_CH-1:0] mode_r;
    logic [7:0]        mute_cnt [NUM_CH];
    logic [CHW-1:0]    rr_ptr;

    logic [NUM_CH-1:0] grant;
    logic [CHW-1:0]    grant_idx;
    logic              grant_any;

    logic signed [DW-1:0] ch_i [NUM_CH];
    logic signed [DW-1:0] ch_q [NUM_CH];

    logic    cfg_change;
    logic    cfg_on_grant;
    s1_rec_t s1_d;
    s1_rec_t s1_r;
    logic    s1_vld;

    logic signed [DW:0] i_x;
    logic signed [DW:0] q_x;
    logic signed [DW:0] sum;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_i[k] = req_i[k*DW +: DW];
        assign ch_q[k] = req_q[k*DW +: DW];
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign req_ready = grant;
    assign mode_q    = mode_r;

    // A write that matches the current mode is a no-op and must not start a mute window.
    assign cfg_change   = cfg_we && ({1'b0, cfg_ch} < (CHW+1)'(NUM_CH))
                          && (cfg_usb != mode_r[cfg_ch]);
    assign cfg_on_grant = cfg_change && (cfg_ch == grant_idx);

    always_comb begin
        s1_d      = '0;
        s1_d.i    = ch_i[grant_idx];
        s1_d.q    = ch_q[grant_idx];
        s1_d.ch   = CH_MAXW'(grant_idx);
        s1_d.usb  = mode_r[grant_idx];
        s1_d.mute = (mute_cnt[grant_idx] != 8'd0) && !cfg_on_grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == CHW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // A cfg write on the same channel as an accepted sample reloads rather than decrements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= {NUM_CH{MODE_USB}};
            for (int k = 0; k < NUM_CH; k++) begin
                mute_cnt[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (cfg_change && (cfg_ch == CHW'(k))) begin
                    mode_r[k]   <= cfg_usb;
                    mute_cnt[k] <= 8'(MUTE_LEN);
                end else if (grant_any && (grant_idx == CHW'(k)) && (mute_cnt[k] != 8'd0)) begin
                    mute_cnt[k] <= mute_cnt[k] - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_r   <= '0;
        end else begin
            s1_vld <= grant_any;
            if (grant_any) begin
                s1_r <= s1_d;
            end
        end
    end

    // DW+1 bits holds any sum or difference, so dropping the LSB always fits in DW.
    always_comb begin
        i_x = {s1_r.i[DW-1], s1_r.i};
        q_x = {s1_r.q[DW-1], s1_r.q};
        sum = (s1_r.usb == MODE_USB) ? (i_x + q_x) : (i_x - q_x);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_ch   <= CHW'(s1_r.ch);
                out_data <= s1_r.mute ? '0 : sum[DW:1];
            end
        end
    end

endmodule

// File: tb/tb_ssb_demod_scheduler.sv
// Bench for ssb_demod_scheduler: directed cases with literal expectations, then random traffic
// compared every cycle against a queue/array reference model of arbitration, mode and mute rules.
module tb_ssb_demod_scheduler;

    localparam int NUM_CH   = 4;
    localparam int DW       = 12;
    localparam int MUTE_LEN = 4;
    localparam int CHW      = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH-1:0]    req_ready;
    logic [NUM_CH*DW-1:0] req_i;
    logic [NUM_CH*DW-1:0] req_q;
    logic                 cfg_we;
    logic [CHW-1:0]       cfg_ch;
    logic                 cfg_usb;
    logic                 out_valid;
    logic [CHW-1:0]       out_ch;
    logic [DW-1:0]        out_data;
    logic [NUM_CH-1:0]    mode_q;

    always #5 clk = ~clk;

    ssb_demod_scheduler #(.NUM_CH(NUM_CH), .DW(DW), .MUTE_LEN(MUTE_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_i     (req_i),
        .req_q     (req_q),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_usb   (cfg_usb),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .mode_q    (mode_q)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus for the next cycle
    logic [NUM_CH-1:0] s_vld;
    int  s_i [NUM_CH];
    int  s_q [NUM_CH];
    bit  s_we;
    int  s_ch;
    bit  s_usb;

    // Reference model: channel modes, remaining mute counts, RR pointer, and a 2-deep output delay line
    typedef struct { bit v; int ch; int data; } exp_t;
    int   m_ptr;
    int   m_mode [NUM_CH];
    int   m_mute [NUM_CH];
    exp_t slot0, slot1;
    int   last_ch, last_data;

    task automatic model_reset();
        m_ptr = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_mode[k] = 1;
            m_mute[k] = 0;
        end
        slot0 = '{0, 0, 0};
        slot1 = '{0, 0, 0};
        last_ch = 0;
        last_data = 0;
    endtask

    task automatic stim_idle();
        s_vld = '0;
        s_we  = 1'b0;
        s_ch  = 0;
        s_usb = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            s_i[k] = 0;
            s_q[k] = 0;
        end
    endtask

    // One clock: compare registered outputs, drive stimulus, check grant, advance the model.
    task automatic step();
        int   g;
        int   sum;
        int   mvec;
        bit   chg;
        exp_t n;
        @(negedge clk);
        if (slot1.v) begin
            last_ch   = slot1.ch;
            last_data = slot1.data;
        end
        mvec = 0;
        for (int k = 0; k < NUM_CH; k++) mvec |= (m_mode[k] << k);
        chk("out_valid", int'(out_valid), int'(slot1.v));
        chk("out_ch", int'(out_ch), last_ch);
        chk("out_data", int'($signed(out_data)), last_data);
        chk("mode_q", int'(mode_q), mvec);
        slot1 = slot0;

        req_valid = s_vld;
        for (int k = 0; k < NUM_CH; k++) begin
            req_i[k*DW +: DW] = s_i[k][DW-1:0];
            req_q[k*DW +: DW] = s_q[k][DW-1:0];
        end
        cfg_we  = s_we;
        cfg_ch  = s_ch[CHW-1:0];
        cfg_usb = s_usb;
        #1;

        g = -1;
        for (int off = 0; off < NUM_CH; off++) begin
            int c;
            c = (m_ptr + off) % NUM_CH;
            if (g < 0 && s_vld[c]) g = c;
        end
        chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));

        chg = s_we && (int'(s_usb) != m_mode[s_ch]);
        n = '{0, 0, 0};
        if (g >= 0) begin
            sum    = (m_mode[g] == 1) ? (s_i[g] + s_q[g]) : (s_i[g] - s_q[g]);
            n.v    = 1;
            n.ch   = g;
            n.data = (m_mute[g] > 0 && !(chg && s_ch == g)) ? 0 : (sum >>> 1);
            m_ptr  = (g + 1) % NUM_CH;
            if (m_mute[g] > 0) m_mute[g]--;
        end
        if (chg) begin
            m_mode[s_ch] = int'(s_usb);
            m_mute[s_ch] = MUTE_LEN;
        end
        slot0 = n;
    endtask

    task automatic send(input int ch, input int i, input int q, input bit we,
                        input int cch, input bit cusb, output int res);
        stim_idle();
        s_vld[ch] = 1'b1;
        s_i[ch]   = i;
        s_q[ch]   = q;
        s_we      = we;
        s_ch      = cch;
        s_usb     = cusb;
        step();
        stim_idle();
        step();
        step();
        res = int'($signed(out_data));
    endtask

    task automatic cfg(input int ch, input bit usb);
        stim_idle();
        s_we  = 1'b1;
        s_ch  = ch;
        s_usb = usb;
        step();
        stim_idle();
    endtask

    task automatic do_reset();
        stim_idle();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        cfg_we = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int res;
        rst_n     = 1'b0;
        req_valid = '0;
        req_i     = '0;
        req_q     = '0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_usb   = 1'b0;
        stim_idle();
        model_reset();
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_mode_q", int'(mode_q), 15);
        @(negedge clk);
        rst_n = 1'b1;

        // Single USB sample on ch0: (100+50)>>>1
        step();
        step();
        stim_idle();
        s_vld[0] = 1'b1; s_i[0] = 100; s_q[0] = 50;
        step();
        chk("t1_ready", int'(req_ready), 1);
        stim_idle();
        step();
        step();
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_ch", int'(out_ch), 0);
        chk("t1_data", int'($signed(out_data)), 75);

        // Extremes; ch1 is switched to LSB so its first MUTE_LEN samples are zeroed
        cfg(1, 1'b0);
        for (int k = 0; k < MUTE_LEN; k++) begin
            send(1, 10, 4, 0, 0, 0, res);
            chk("t2_mute", res, 0);
        end
        send(1, -2048, 2047, 0, 0, 0, res);
        chk("t2_lsb_min", res, -2048);
        send(0, -2048, -2048, 0, 0, 0, res);
        chk("t2_usb_min", res, -2048);
        send(1, 2047, -2048, 0, 0, 0, res);
        chk("t2_lsb_max", res, 2047);

        // Round-robin order from reset, then only ch1 and ch3 requesting
        do_reset();
        for (int k = 0; k < 8; k++) begin
            stim_idle();
            s_vld = 4'b1111;
            step();
            chk("t3_grant_all", int'(req_ready), 1 << (k % 4));
        end
        for (int k = 0; k < 4; k++) begin
            stim_idle();
            s_vld = 4'b1010;
            step();
            chk("t3_grant_odd", int'(req_ready), (k % 2 == 0) ? 2 : 8);
        end
        stim_idle();
        step();
        step();

        // Mute window after USB->LSB on ch2; a repeated LSB write is a no-op
        cfg(2, 1'b0);
        for (int k = 0; k < 6; k++) begin
            send(2, 400, 100, 0, 0, 0, res);
            chk("t4_seq", res, (k < MUTE_LEN) ? 0 : 150);
        end
        cfg(2, 1'b0);
        send(2, 400, 100, 0, 0, 0, res);
        chk("t4_repeat", res, 150);

        // Back to USB, drain, then a write coinciding with acceptance keeps the old mode
        cfg(2, 1'b1);
        for (int k = 0; k < MUTE_LEN; k++) send(2, 400, 100, 0, 0, 0, res);
        send(2, 400, 100, 1, 2, 1'b0, res);
        chk("t5_same_cycle", res, 250);
        for (int k = 0; k < MUTE_LEN; k++) begin
            send(2, 400, 100, 0, 0, 0, res);
            chk("t5_mute", res, 0);
        end
        send(2, 400, 100, 0, 0, 0, res);
        chk("t5_after", res, 150);

        // Random traffic with occasional mode writes
        for (int n = 0; n < 1500; n++) begin
            s_vld = NUM_CH'($urandom);
            for (int k = 0; k < NUM_CH; k++) begin
                s_i[k] = int'($urandom_range(4095, 0)) - 2048;
                s_q[k] = int'($urandom_range(4095, 0)) - 2048;
            end
            s_we  = ($urandom_range(7, 0) == 0);
            s_ch  = int'($urandom_range(NUM_CH - 1, 0));
            s_usb = 1'($urandom);
            step();
        end

        // Asynchronous reset with both pipeline stages occupied
        stim_idle();
        s_vld = 4'b1111;
        for (int k = 0; k < NUM_CH; k++) s_i[k] = 300 + k;
        step();
        step();
        chk("t6_pre_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", int'(out_valid), 0);
        chk("t6_async_data", int'(out_data), 0);
        chk("t6_async_mode", int'(mode_q), 15);
        stim_idle();
        req_valid = '0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("t6_post_valid", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
